tt_um_jleugeri_ttt_event_queue: RTL and testbench
=================================================

# tt_um_jleugeri_ttt_event_queue

Downstream stage of the TTT processor core: samples the core's per-neuron `token_startstop` result on every `clock_fast` scan slot and turns each non-zero result into a tagged event word. It interleaves timestep markers on each `step` strobe and buffers everything in a first-word-fall-through FIFO. The buffered words drain through a valid/ready port toward the chip's output serializer.

## Interface
- `NUM_PROCESSORS`, 10, neurons scanned by the core; `ID_BITS = $clog2(NUM_PROCESSORS)`
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `DROP_BITS`, 8, width of the saturating dropped-event counter
- `TS_BITS`, 8, timestep counter width; used only with `TTT_EVQ_TIMESTAMP_EN`
- `clock_fast`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  core presents a scan result this cycle
- `neuron_id`  in  ID_BITS  neuron the result belongs to
- `token_startstop`  in  2  bit1 = start, bit0 = stop
- `step`  in  1  one-cycle timestep strobe
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  W  {kind[1:0], neuron_id}; W = 2+ID_BITS, or 2+ID_BITS+TS_BITS with timestamp
- `overflow`  out  1  sticky: at least one word dropped
- `drop_count`  out  DROP_BITS  dropped words, saturating

## Operation
- Kind encoding: 00 timestep marker (id field = 0); 01 stop; 10 start; 11 start+stop in the same slot (one word).
- Event push: `in_valid && token_startstop != 0`. A result of 00 is never queued.
- Marker: `step` sets `marker_pending`. The marker is pushed in the first cycle, including the `step` cycle itself, with no event push. An event always wins a same-cycle conflict, so a step's marker follows every event of the preceding timestep.
- A second `step` while `marker_pending` is set is merged into the pending marker and counted as one dropped word.
- Push is accepted when the FIFO is not full, or when a pop happens in the same cycle (full + push + pop leaves it full and loses nothing).
- Push refused because full: the word is discarded, `overflow` is set, and `drop_count` increments unless it is saturated at all ones. A refused marker is dropped the same way and clears `marker_pending`.
- Pop: `out_valid && out_ready`. Pointers wrap modulo DEPTH; a separate occupancy count of `$clog2(DEPTH)+1` bits distinguishes full from empty.
- Only `reset` clears `overflow` and `drop_count`.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `overflow` 0, `drop_count` 0; FIFO empty, `marker_pending` 0, timestep counter 0.
- Push→`out_valid` latency: 1 cycle. An event pushed into an empty FIFO at edge N is visible after edge N.
- First-word fall-through: `out_data` is stable while `out_valid && !out_ready`; the next word appears the cycle after a pop.
- Throughput: 1 push and 1 pop per cycle.
- Reset mid-operation: all contents are discarded at the reset edge, and inputs in the reset cycle are ignored.

## Configuration
- `TTT_EVQ_TIMESTAMP_EN` defined: a TS_BITS counter increments (wrapping) on each accepted `step`. Each event word carries the counter value at push time. Each marker carries the post-increment value.
- Not defined: no counter, and `out_data` is 2+ID_BITS wide.

## Structure
- Package `tt_um_jleugeri_ttt_pkg`: `evq_kind_t` enum (MARKER, STOP, START, STARTSTOP) and the start/stop bit-position constants, shared with the processor core.
- Sub-module `tt_um_jleugeri_ttt_fifo`: parameterised WIDTH/DEPTH first-word-fall-through FIFO with count-based full/empty. The queue module holds the encoding, marker arbitration and drop accounting.

## Test plan
- Reset, then `in_valid`=1, `neuron_id`=3, `token_startstop`=10, with `out_ready`=1 → next cycle `out_valid`=1, `out_data`={10,3}; one cycle later `out_valid`=0.
- Scan ids 0..9 with results only for id 2 (01) and id 7 (11), then `step` on the id 7 slot → words {01,2}, {11,7}, {00,0} in that order.
- `out_ready`=0, push 8 events → FIFO full; a 9th event → `overflow`=1, `drop_count`=1; the first 8 words drain intact in order.
- Full FIFO with `out_ready`=1 and a push in the same cycle → push accepted, `drop_count` unchanged, FIFO stays full.
- Assert `reset` for one cycle while holding 5 words → `out_valid`=0 next cycle; `overflow`/`drop_count` are 0.
- With `TTT_EVQ_TIMESTAMP_EN`: three `step`s, then an event for id 4 → markers carry ts 1, 2, 3, and the event carries ts 3.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared TTT definitions: event-word kind encoding and token bit positions.
// Used by the processor core and the event queue.
package tt_um_jleugeri_ttt_pkg;

  typedef enum logic [1:0] {
    MARKER    = 2'b00,
    STOP      = 2'b01,
    START     = 2'b10,
    STARTSTOP = 2'b11
  } evq_kind_t;

  localparam int TOKEN_START_BIT = 1;
  localparam int TOKEN_STOP_BIT  = 0;

  function automatic evq_kind_t token_kind(input logic [1:0] token_startstop);
    return evq_kind_t'({token_startstop[TOKEN_START_BIT], token_startstop[TOKEN_STOP_BIT]});
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_fifo.sv
// First-word-fall-through FIFO; an occupancy counter separates full from empty.
// A push is accepted when not full or when a pop happens in the same cycle.
module tt_um_jleugeri_ttt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             full
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [PTR_BITS-1:0] rd_ptr_reg;
  logic [CNT_BITS-1:0] count_reg;
  logic                do_pop;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == CNT_BITS'(DEPTH));
  assign do_pop  = pop && valid;
  assign push_ok = push && (!full || do_pop);
  // Gate the head word so the port reads zero while empty (including after reset).
  assign data    = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      end
      case ({push_ok, do_pop})
        2'b10:   count_reg <= count_reg + CNT_BITS'(1);
        2'b01:   count_reg <= count_reg - CNT_BITS'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_event_queue.sv
// TTT event queue: encodes scan results and timestep markers into words and buffers them.
// Optional macro TTT_EVQ_TIMESTAMP_EN appends a TS_BITS timestep counter to every word.
module tt_um_jleugeri_ttt_event_queue
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int DEPTH          = 8,
  parameter int DROP_BITS      = 8,
  parameter int TS_BITS        = 8,
  localparam int ID_BITS       = $clog2(NUM_PROCESSORS),
`ifdef TTT_EVQ_TIMESTAMP_EN
  localparam int TS_WIDTH      = TS_BITS,
`else
  localparam int TS_WIDTH      = 0 * TS_BITS,
`endif
  localparam int W             = 2 + ID_BITS + TS_WIDTH
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [ID_BITS-1:0]   neuron_id,
  input  logic [1:0]           token_startstop,
  input  logic                 step,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 overflow,
  output logic [DROP_BITS-1:0] drop_count
);

  logic                 marker_pending_reg;
  logic                 overflow_reg;
  logic [DROP_BITS-1:0] drop_count_reg;

  logic                 event_push;
  logic                 marker_req;
  logic                 marker_push;
  logic                 push;
  logic                 push_ok;
  logic                 push_drop;
  logic                 merge_drop;
  logic [1:0]           drop_inc;
  logic [DROP_BITS:0]   drop_sum;
  evq_kind_t            kind;
  logic [ID_BITS-1:0]   word_id;
  logic [W-1:0]         word;

  // Events always win the slot; a pending marker waits for the first idle slot.
  assign event_push  = in_valid && (token_startstop != 2'b00);
  assign marker_req  = marker_pending_reg || step;
  assign marker_push = marker_req && !event_push;
  assign push        = event_push || marker_push;
  assign push_drop   = push && !push_ok;
  assign merge_drop  = step && marker_pending_reg;

  assign kind    = event_push ? token_kind(token_startstop) : MARKER;
  assign word_id = event_push ? neuron_id : '0;

`ifdef TTT_EVQ_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_reg;
  logic               step_accept;
  logic [TS_BITS-1:0] ts_inc;

  // A marker carries the post-increment value even when pushed in the step cycle itself.
  assign step_accept = step && !marker_pending_reg;
  assign ts_inc      = ts_reg + TS_BITS'(1);
  assign word        = {kind, word_id, event_push ? ts_reg : (step_accept ? ts_inc : ts_reg)};

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      ts_reg <= '0;
    end else if (step_accept) begin
      ts_reg <= ts_inc;
    end
  end
`else
  assign word = {kind, word_id};
`endif

  // Two words can be lost in one cycle: a merged step plus a refused push.
  assign drop_inc = {1'b0, merge_drop} + {1'b0, push_drop};
  assign drop_sum = {1'b0, drop_count_reg} + {{(DROP_BITS-1){1'b0}}, drop_inc};

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      marker_pending_reg <= 1'b0;
      overflow_reg       <= 1'b0;
      drop_count_reg     <= '0;
    end else begin
      marker_pending_reg <= marker_push ? 1'b0 : marker_req;
      if (drop_inc != 2'b00) begin
        overflow_reg   <= 1'b1;
        drop_count_reg <= drop_sum[DROP_BITS] ? '1 : drop_sum[DROP_BITS-1:0];
      end
    end
  end

  tt_um_jleugeri_ttt_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) fifo (
    .clk      (clock_fast),
    .srst     (reset),
    .push     (push),
    .push_data(word),
    .push_ok  (push_ok),
    .pop      (out_ready),
    .valid    (out_valid),
    .data     (out_data),
    .full     ()
  );

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_queue.sv
// Scoreboard bench for the TTT event queue: expected words are queued as stimulus is
// driven and compared as the DUT pops them. Honours TTT_EVQ_TIMESTAMP_EN when defined.
module tb_tt_um_jleugeri_ttt_event_queue;
  localparam int ID_BITS = 4;
`ifdef TTT_EVQ_TIMESTAMP_EN
  localparam int TSW = 8;
`else
  localparam int TSW = 0;
`endif
  localparam int W = 2 + ID_BITS + TSW;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [ID_BITS-1:0] neuron_id;
  logic [1:0]         token_startstop;
  logic               step;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic               overflow;
  logic [7:0]         drop_count;

  tt_um_jleugeri_ttt_event_queue dut (
    .clock_fast     (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .neuron_id      (neuron_id),
    .token_startstop(token_startstop),
    .step           (step),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ts_m     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mkw(input logic [1:0] k, input logic [3:0] id, input int ts);
    logic [13:0] all;
    logic [7:0]  t;
    t   = 8'(ts);
    all = {k, id, t};
    return W'(all >> (8 - TSW));
  endfunction

  // Pop side of the scoreboard: one line per word leaving the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [W-1:0] w;
      w = 'x;
      if (exp_q.size() > 0) w = exp_q.pop_front();
      $display("pop word 0x%0h (expected 0x%0h)", out_data, w);
      check("pop_word", 32'(out_data), 32'(w));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid        = 1'b0;
    neuron_id       = '0;
    token_startstop = 2'b00;
    step            = 1'b0;
  endtask

  task automatic drive_event(input int id, input logic [1:0] tss, input bit accept);
    in_valid        = 1'b1;
    neuron_id       = ID_BITS'(id);
    token_startstop = tss;
    if (accept) exp_q.push_back(mkw(tss, 4'(id), ts_m));
    tick();
    idle();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single event, latency one cycle.
    out_ready = 1'b1;
    drive_event(3, 2'b10, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    tick();
    check("single_gone", 32'(out_valid), 32'd0);

    // Scan with step on id 7: event wins, marker follows.
    for (int i = 0; i < 10; i++) begin
      in_valid        = 1'b1;
      neuron_id       = ID_BITS'(i);
      token_startstop = (i == 2) ? 2'b01 : (i == 7) ? 2'b11 : 2'b00;
      step            = (i == 7);
      if (token_startstop != 2'b00) exp_q.push_back(mkw(token_startstop, 4'(i), ts_m));
      if (i == 7) begin
        ts_m++;
        exp_q.push_back(mkw(2'b00, 4'd0, ts_m));
      end
      tick();
    end
    idle();
    wait_drain("scan_drain");

    // Fill to full, then one refused event.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_event(i, 2'((i % 3) + 1), 1'b1);
    drive_event(8, 2'b10, 1'b0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drop_count", 32'(drop_count), 32'd1);
    check("full_head", 32'(out_data), 32'(exp_q[0]));
    tick();
    check("full_head_stable", 32'(out_data), 32'(exp_q[0]));
    out_ready = 1'b1;
    wait_drain("full_drain");

    // Full + push + pop in the same cycle loses nothing and stays full.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_event(9 - i, 2'b01, 1'b1);
    out_ready = 1'b1;
    drive_event(5, 2'b11, 1'b1);
    out_ready = 1'b0;
    check("pushpop_drop_count", 32'(drop_count), 32'd1);
    drive_event(6, 2'b01, 1'b0);
    check("still_full_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    wait_drain("pushpop_drain");

    // Reset while holding words; the event in the reset cycle is ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_event(i, 2'b10, 1'b1);
    reset           = 1'b1;
    in_valid        = 1'b1;
    neuron_id       = 4'd1;
    token_startstop = 2'b01;
    tick();
    exp_q.delete();
    ts_m  = 0;
    reset = 1'b0;
    idle();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    tick();
    check("midrst_ignored", 32'(out_valid), 32'd0);

    // Three bare steps, then an event carrying the latest timestep.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      ts_m++;
      exp_q.push_back(mkw(2'b00, 4'd0, ts_m));
      tick();
    end
    step = 1'b0;
    drive_event(4, 2'b10, 1'b1);
    wait_drain("ts_drain");

    // Second step while a marker is pending merges and counts one drop.
    out_ready = 1'b0;
    step = 1'b1;
    drive_event(1, 2'b01, 1'b1);
    ts_m++;
    step = 1'b1;
    drive_event(2, 2'b10, 1'b1);
    exp_q.push_back(mkw(2'b00, 4'd0, ts_m));
    tick();
    check("merge_drop_count", 32'(drop_count), 32'd1);
    check("merge_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    wait_drain("merge_drain");
    tick();
    check("final_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
